// File: rtl/mc_fsm_pkg.sv
// Shared constants for the multicycle control FSM: state numbers, opcodes, function codes,
// and small state-class helpers used to build the registered outputs.
package mc_fsm_pkg;

  // State numbering; the top zero-extends these onto its SW-bit state register.
  localparam int unsigned S_FETCH    = 0;
  localparam int unsigned S_DECODE   = 1;
  localparam int unsigned S_MEMADR   = 2;
  localparam int unsigned S_MEMREAD  = 3;
  localparam int unsigned S_MEMWB    = 4;
  localparam int unsigned S_MEMWRITE = 5;
  localparam int unsigned S_EXECUTE  = 6;
  localparam int unsigned S_ALUWB    = 7;
  localparam int unsigned S_BEQ      = 8;
  localparam int unsigned S_JUMP     = 9;
  localparam int unsigned S_IMMWB    = 10;
  localparam int unsigned S_BNE      = 11;
  localparam int unsigned S_SLTIEX   = 12;
  localparam int unsigned S_MULT     = 13;
  localparam int unsigned S_MFLO     = 14;
  localparam int unsigned S_LUIEX    = 15;
  localparam int unsigned S_DIV      = 16;
  localparam int unsigned S_TRAP     = 17;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_MFLO = 6'b010010;

  // States that hold a memory access open.
  function automatic logic is_mem_state(input int unsigned s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

  // States that run the multi-cycle multiply/divide counter.
  function automatic logic is_mul_state(input int unsigned s);
    return (s == S_MULT) || (s == S_DIV);
  endfunction

  // States that always finish their instruction in a single cycle.
  function automatic logic is_final_state(input int unsigned s);
    return (s == S_MEMWB) || (s == S_ALUWB) || (s == S_BEQ) || (s == S_JUMP) ||
           (s == S_IMMWB) || (s == S_BNE) || (s == S_MFLO) || (s == S_TRAP);
  endfunction

endpackage

// File: rtl/mc_cycle_counter.sv
// Load-and-count-down counter timing the MULT/DIV execute states.
module mc_cycle_counter #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  // Load has priority; decrement is held off at zero so the count can never wrap.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle CPU control FSM with memory ready/wait handshake, multi-cycle MULT/DIV
// execute and an illegal-instruction trap. NS exposes the registered state.
module mc_control_fsm
  import mc_fsm_pkg::*;
#(
  parameter int unsigned SW            = 5,
  parameter int unsigned MUL_CYCLES    = 4,
  parameter int unsigned MEM_HANDSHAKE = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    Op,
  input  logic [5:0]    Funct,
  input  logic          mem_ready,
  output logic [SW-1:0] NS,
  output logic          mem_req,
  output logic          mul_busy,
  output logic          instr_done,
  output logic          illegal
);

  localparam int unsigned CntW = $clog2(MUL_CYCLES + 1);

  logic [SW-1:0] state_q, state_d;
  logic          mem_req_q, mul_busy_q, illegal_q, final_q, memwr_q;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic          rdy;
  int unsigned   cur_st, nxt_st;

  function automatic logic [SW-1:0] enc(input int unsigned s);
    return SW'(s);
  endfunction

  // With the handshake disabled memory behaves as always ready.
  assign rdy    = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign cur_st = 32'(state_q);
  assign nxt_st = 32'(state_d);

  mc_cycle_counter #(
    .Width (CntW)
  ) u_cnt (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (CntW'(MUL_CYCLES - 1)),
    .zero_o     (cnt_zero)
  );

  // Next-state decode; unused encodings fall through to FETCH.
  always_comb begin
    state_d  = enc(S_FETCH);
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (cur_st)
      S_FETCH:    state_d = rdy ? enc(S_DECODE) : enc(S_FETCH);
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW, OP_ADDI: state_d = enc(S_MEMADR);
          OP_RTYPE:              state_d = enc(S_EXECUTE);
          OP_BEQ:                state_d = enc(S_BEQ);
          OP_J:                  state_d = enc(S_JUMP);
          OP_BNE:                state_d = enc(S_BNE);
          OP_SLTI:               state_d = enc(S_SLTIEX);
          OP_LUI:                state_d = enc(S_LUIEX);
          default:               state_d = enc(S_TRAP);
        endcase
      end
      S_MEMADR: begin
        // Op changing between DECODE and MEMADR is treated as illegal.
        case (Op)
          OP_LW:   state_d = enc(S_MEMREAD);
          OP_SW:   state_d = enc(S_MEMWRITE);
          OP_ADDI: state_d = enc(S_IMMWB);
          default: state_d = enc(S_TRAP);
        endcase
      end
      S_MEMREAD:  state_d = rdy ? enc(S_MEMWB) : enc(S_MEMREAD);
      S_MEMWRITE: state_d = rdy ? enc(S_FETCH) : enc(S_MEMWRITE);
      S_EXECUTE: begin
        case (Funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL: state_d = enc(S_ALUWB);
          F_MULT: begin
            state_d  = enc(S_MULT);
            cnt_load = 1'b1;
          end
          F_DIV: begin
            state_d  = enc(S_DIV);
            cnt_load = 1'b1;
          end
          F_MFLO:  state_d = enc(S_MFLO);
          default: state_d = enc(S_TRAP);
        endcase
      end
      S_SLTIEX, S_LUIEX: state_d = enc(S_IMMWB);
      S_MULT, S_DIV: begin
        if (!cnt_zero) begin
          state_d = state_q;
          cnt_dec = 1'b1;
        end else begin
          state_d = enc(S_FETCH);
        end
      end
      default: state_d = enc(S_FETCH);
    endcase
  end

  // State register plus registered state-class flags derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= enc(S_FETCH);
      mem_req_q  <= 1'b1;
      mul_busy_q <= 1'b0;
      illegal_q  <= 1'b0;
      final_q    <= 1'b0;
      memwr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= is_mem_state(nxt_st);
      mul_busy_q <= is_mul_state(nxt_st);
      illegal_q  <= (nxt_st == S_TRAP);
      final_q    <= is_final_state(nxt_st);
      memwr_q    <= (nxt_st == S_MEMWRITE);
    end
  end

  assign NS         = state_q;
  assign mem_req    = mem_req_q;
  assign mul_busy   = mul_busy_q;
  assign illegal    = illegal_q;
  // SW completes on the cycle memory accepts; MULT/DIV on its last counted cycle.
  assign instr_done = final_q | (memwr_q & rdy) | (mul_busy_q & cnt_zero);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a default instance (handshake on, 4-cycle MULT/DIV) and a legacy
// instance (handshake off, 1-cycle MULT/DIV), checked against an instruction-path model.
module tb_mc_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_m, reset_l, rdy_m, rdy_l;
  logic [5:0] op_m, fn_m, op_l, fn_l;
  logic [4:0] ns_m, ns_l;
  logic       mreq_m, mreq_l, mbusy_m, mbusy_l, done_m, done_l, ill_m, ill_l;

  mc_control_fsm #(.SW(5), .MUL_CYCLES(4), .MEM_HANDSHAKE(1)) dut (
    .clk(clk), .reset(reset_m), .Op(op_m), .Funct(fn_m), .mem_ready(rdy_m),
    .NS(ns_m), .mem_req(mreq_m), .mul_busy(mbusy_m), .instr_done(done_m), .illegal(ill_m)
  );

  mc_control_fsm #(.SW(5), .MUL_CYCLES(1), .MEM_HANDSHAKE(0)) dut_leg (
    .clk(clk), .reset(reset_l), .Op(op_l), .Funct(fn_l), .mem_ready(rdy_l),
    .NS(ns_l), .mem_req(mreq_l), .mul_busy(mbusy_l), .instr_done(done_l), .illegal(ill_l)
  );

  logic       sel;  // 0: default instance, 1: legacy instance
  logic [4:0] o_ns;
  logic       o_mreq, o_mbusy, o_done, o_ill;
  assign o_ns    = sel ? ns_l : ns_m;
  assign o_mreq  = sel ? mreq_l : mreq_m;
  assign o_mbusy = sel ? mbusy_l : mbusy_m;
  assign o_done  = sel ? done_l : done_m;
  assign o_ill   = sel ? ill_l : ill_m;

  int n_tests = 0;
  int n_fail  = 0;
  int mul_cyc = 4;
  int hs      = 1;
  int path[$];

  logic [5:0] op_tab [9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010,
                             6'b001000, 6'b000101, 6'b001010, 6'b001111};
  logic [5:0] fn_tab [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                             6'b000000, 6'b011000, 6'b011010, 6'b010010};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sequence of distinct states an instruction visits, straight from the ISA dispatch rules.
  task automatic build_path(input logic [5:0] op, input logic [5:0] fn);
    path.delete();
    path.push_back(0);
    path.push_back(1);
    case (op)
      6'b100011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
      6'b101011: begin path.push_back(2); path.push_back(5); end
      6'b001000: begin path.push_back(2); path.push_back(10); end
      6'b000100: path.push_back(8);
      6'b000010: path.push_back(9);
      6'b000101: path.push_back(11);
      6'b001010: begin path.push_back(12); path.push_back(10); end
      6'b001111: begin path.push_back(15); path.push_back(10); end
      6'b000000: begin
        path.push_back(6);
        case (fn)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000: path.push_back(7);
          6'b011000: path.push_back(13);
          6'b011010: path.push_back(16);
          6'b010010: path.push_back(14);
          default:   path.push_back(17);
        endcase
      end
      default: path.push_back(17);
    endcase
  endtask

  // Runs one instruction on the selected instance; rmode 0 random ready, 1 always, 2 never.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int rmode);
    int idx = 0;
    int stay = 0;
    int guard = 0;
    int cur;
    logic r, eff, leave, last;
    build_path(op, fn);
    if (sel) begin op_l = op; fn_l = fn; end else begin op_m = op; fn_m = fn; end
    while (idx < path.size()) begin
      @(negedge clk);
      r = (rmode == 0) ? ($urandom_range(0, 3) != 0) : (rmode == 1);
      if (sel) rdy_l = r; else rdy_m = r;
      #1;
      cur  = path[idx];
      eff  = (hs != 0) ? r : 1'b1;
      last = (idx == path.size() - 1);
      if (cur == 0 || cur == 3 || cur == 5) leave = eff;
      else if (cur == 13 || cur == 16)      leave = (stay + 1 >= mul_cyc);
      else                                  leave = 1'b1;
      chk("ns", 32'(o_ns), cur);
      chk("mem_req", 32'(o_mreq), 32'(cur == 0 || cur == 3 || cur == 5));
      chk("mul_busy", 32'(o_mbusy), 32'(cur == 13 || cur == 16));
      chk("illegal", 32'(o_ill), 32'(cur == 17));
      chk("instr_done", 32'(o_done), 32'(last && leave));
      if (leave) begin idx++; stay = 0; end else stay++;
      guard++;
      if (guard > 300) begin
        n_tests++;
        n_fail++;
        $error("FAIL timeout observed=%0d expected<=%0d", guard, 300);
        break;
      end
    end
  endtask

  task automatic step(input logic r);
    @(negedge clk);
    rdy_m = r;
    #1;
  endtask

  task automatic rand_instr(input int rmode);
    int k;
    logic [5:0] op, fn;
    k  = $urandom_range(0, 10);
    op = (k < 9) ? op_tab[k] : 6'($urandom);
    k  = $urandom_range(0, 10);
    fn = (k < 9) ? fn_tab[k] : 6'($urandom);
    run_instr(op, fn, rmode);
  endtask

  initial begin
    sel = 1'b0;
    reset_m = 1'b1; reset_l = 1'b1;
    rdy_m = 1'b0; rdy_l = 1'b0;
    op_m = 6'b111111; fn_m = 6'b111111; op_l = 6'b0; fn_l = 6'b0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_ns", 32'(ns_m), 0);
    chk("rst_mem_req", 32'(mreq_m), 1);
    chk("rst_mul_busy", 32'(mbusy_m), 0);
    chk("rst_instr_done", 32'(done_m), 0);
    chk("rst_illegal", 32'(ill_m), 0);
    reset_m = 1'b0;

    // Directed: illegal opcode, illegal funct, MULT, DIV, LW, SW
    run_instr(6'b111111, 6'b000000, 0);
    run_instr(6'b000000, 6'b111111, 0);
    run_instr(6'b000000, 6'b011000, 1);
    run_instr(6'b000000, 6'b011010, 0);
    run_instr(6'b100011, 6'b000000, 0);
    run_instr(6'b101011, 6'b000000, 0);

    // Reset during the second MULT cycle
    op_m = 6'b000000; fn_m = 6'b011000;
    step(1'b1); step(1'b1); step(1'b1); step(1'b1); step(1'b1);
    chk("pre_rst_ns", 32'(ns_m), 13);
    chk("pre_rst_mul_busy", 32'(mbusy_m), 1);
    reset_m = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ns", 32'(ns_m), 0);
    chk("mid_rst_mul_busy", 32'(mbusy_m), 0);
    chk("mid_rst_mem_req", 32'(mreq_m), 1);
    reset_m = 1'b0;
    run_instr(6'b000000, 6'b100000, 1);
    run_instr(6'b000000, 6'b011000, 0);

    // Randomized instructions on the default instance
    for (int i = 0; i < 60; i++) rand_instr(0);

    // Legacy instance: every opcode with mem_ready held low, then random mixes
    sel = 1'b1; mul_cyc = 1; hs = 0;
    @(posedge clk); #1;
    reset_l = 1'b0;
    for (int i = 0; i < 9; i++) run_instr(op_tab[i], 6'b011000, 2);
    run_instr(6'b000000, 6'b100000, 2);
    run_instr(6'b000000, 6'b010010, 2);
    for (int i = 0; i < 40; i++) rand_instr(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
